// File: rtl/dot_seq_pkg.sv
// Shared definitions for the dot-product operand sequencer.
package dot_seq_pkg;

  localparam int DEF_INPUT_WIDTH  = 18;
  localparam int DEF_OUTPUT_WIDTH = 40;
  localparam int DEF_COUNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    DRAIN   = 2'd1,
    CAPTURE = 2'd2,
    CLEAR   = 2'd3
  } state_t;

endpackage

// File: rtl/dot_seq.sv
// Feeds operand pairs into an external multiply-accumulator one per cycle and
// captures each packet's sum and beat count onto a ready/valid result port.
//
// state   | meaning
// ACCUM   | accepting beats, counting them
// DRAIN   | last product being absorbed by the accumulator
// CAPTURE | latch sum/count into the result register (stalls on unread result)
// CLEAR   | accumulator cleared via macc_reset
module dot_seq
  import dot_seq_pkg::*;
#(
  parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
  parameter int COUNT_WIDTH  = DEF_COUNT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [INPUT_WIDTH-1:0]  s_a,
  input  logic [INPUT_WIDTH-1:0]  s_b,
  input  logic                    s_last,
  output logic [INPUT_WIDTH-1:0]  macc_a,
  output logic [INPUT_WIDTH-1:0]  macc_b,
  output logic                    macc_reset,
  input  logic [OUTPUT_WIDTH-1:0] macc_y,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [OUTPUT_WIDTH-1:0] m_data,
  output logic [COUNT_WIDTH-1:0]  m_count
);

  state_t                  r_state;
  logic                    r_s_ready;
  logic [INPUT_WIDTH-1:0]  r_a;
  logic [INPUT_WIDTH-1:0]  r_b;
  logic [COUNT_WIDTH-1:0]  r_count;
  logic                    r_m_valid;
  logic [OUTPUT_WIDTH-1:0] r_m_data;
  logic [COUNT_WIDTH-1:0]  r_m_count;
  logic                    w_fire;

  assign w_fire = s_valid && r_s_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ACCUM;
      r_s_ready <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_count   <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_count <= '0;
    end else begin
      // The accumulator adds every edge, so idle cycles must present zeros.
      r_a <= w_fire ? s_a : '0;
      r_b <= w_fire ? s_b : '0;
      if (r_m_valid && m_ready) r_m_valid <= 1'b0;
      case (r_state)
        ACCUM: begin
          r_s_ready <= !(w_fire && s_last);
          if (w_fire) begin
            if (r_count != '1) r_count <= r_count + COUNT_WIDTH'(1);
            if (s_last) r_state <= DRAIN;
          end
        end
        DRAIN: r_state <= CAPTURE;
        CAPTURE: begin
          if (!(r_m_valid && !m_ready)) begin
            r_m_data  <= macc_y;
            r_m_count <= r_count;
            r_m_valid <= 1'b1;
            r_count   <= '0;
            r_state   <= CLEAR;
          end
        end
        CLEAR: begin
          r_state   <= ACCUM;
          r_s_ready <= 1'b1;
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign s_ready    = r_s_ready;
  assign macc_a     = r_a;
  assign macc_b     = r_b;
  assign macc_reset = reset | (r_state == CLEAR);
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_count    = r_m_count;

endmodule

// File: doc/dot_seq.md
# dot_seq

Operand sequencer and result capture stage for the multiply-accumulate datapath. It accepts a ready/valid stream of operand pairs grouped into packets by a `last` flag, and drives them one per cycle into the accumulator. Each packet's final sum is read back from the accumulator, clears the accumulator, and the result and beat count are presented on a ready/valid output. It sits directly upstream of the accumulator and also consumes its output.

## Interface
- `INPUT_WIDTH`, default 18: operand width, unsigned.
- `OUTPUT_WIDTH`, default 40: accumulator/result width.
- `COUNT_WIDTH`, default 16: beat-count width.

- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `s_valid`  in  1  operand beat valid.
- `s_ready`  out  1  operand beat accepted when `s_valid && s_ready`.
- `s_a`  in  INPUT_WIDTH  operand A.
- `s_b`  in  INPUT_WIDTH  operand B.
- `s_last`  in  1  final beat of packet.
- `macc_a`  out  INPUT_WIDTH  registered operand A to accumulator.
- `macc_b`  out  INPUT_WIDTH  registered operand B to accumulator.
- `macc_reset`  out  1  accumulator clear.
- `macc_y`  in  OUTPUT_WIDTH  accumulator value. Updates every edge as `y + a*b`.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  result accepted when `m_valid && m_ready`.
- `m_data`  out  OUTPUT_WIDTH  packet sum.
- `m_count`  out  COUNT_WIDTH  beats in packet, saturating.

## Operation
- The accumulator adds `macc_a*macc_b` on every edge. `macc_a` and `macc_b` must therefore be 0 on every cycle that does not carry an accepted beat.
- Operand registers: on a fire, load `s_a` and `s_b`; otherwise load 0.
- `macc_reset = reset | (state == CLEAR)`.
- States:
  - ACCUM: `s_ready = 1`. Each fire increments the beat counter (saturates at all-ones). A fire with `s_last` set moves to DRAIN.
  - DRAIN: `s_ready = 0`. Operand registers load 0. The accumulator absorbs the last product. Next state is CAPTURE.
  - CAPTURE: `s_ready = 0`.
    - If `m_valid && !m_ready`, stay in CAPTURE (stall).
    - Otherwise: `m_data <= macc_y`, `m_count <= counter`, `m_valid <= 1`, clear the counter, go to CLEAR.
  - CLEAR: `s_ready = 0`. `macc_reset` is high, so the accumulator is 0 at the next edge. Next state is ACCUM.
- Output register behaviour:
  - `m_valid` clears on `m_valid && m_ready` unless CAPTURE loads a new result in the same cycle.
  - `m_data` and `m_count` are stable while `m_valid && !m_ready`.
- Arithmetic: no overflow detection. The result is whatever the accumulator holds, modulo 2^OUTPUT_WIDTH.
- Every packet has at least one beat; the `last` beat counts.
- Reset values: `s_ready = 0`, `macc_a = 0`, `macc_b = 0`, `macc_reset = 1`, `m_valid = 0`, `m_data = 0`, `m_count = 0`. State is ACCUM, counter is 0.
- `s_ready` rises the first cycle after reset deasserts.
- Reset mid-packet discards the partial sum and count. `macc_reset` clears the accumulator in the same cycle.

## Timing
- Last beat fires at edge E0.
  - E1: accumulator holds the final sum.
  - E2: `m_valid = 1` with `m_data` = that sum.
  - E3: accumulator is 0, and `s_ready = 1` again.
- Cost per packet is N beat cycles plus 3 overhead cycles. There is no back-to-back packet overlap.
- A beat fired at E3 or later contributes to `macc_y` at the following edge.
- CAPTURE stall: `s_ready` stays 0 and the accumulator holds its value, because the operands are 0.
- Simultaneous `m_ready` and CAPTURE load: the old result is consumed and the new one is loaded in the same edge. `m_valid` stays 1.
- No combinational path from `s_valid`/`m_ready` to `s_ready`; `s_ready` is state-decoded.

## Structure
- Shared package `dot_seq_pkg` holds the state enum (ACCUM, DRAIN, CAPTURE, CLEAR) and the default width constants.
- Single flat module; no sub-module is warranted.
- The accumulator is instantiated alongside this block by the parent, not inside it.

## Test plan
All scenarios run against a cycle-accurate accumulator, either the real one or a model.
- Packet (2,3), (4,5), (6,7,last) → `m_data = 68`, `m_count = 3`, `m_valid` two edges after the last fire.
- Single beat (0x3FFFF, 0x3FFFF, last) → `m_data = 0xFFFF80001`, `m_count = 1`.
- Bubbles: `s_valid` low for 3 cycles between beats (1,1), (2,2,last) → `macc_a`/`macc_b` are 0 during the bubbles; `m_data = 5`, `m_count = 2`.
- `m_ready` held low. Packet (1,1,last) then packet (3,3,last):
  - First result 1 is held.
  - The block stalls in CAPTURE with `s_ready = 0`.
  - Raising `m_ready` yields 1, then 9, in order.
- Reset after two beats (5,5), (5,5) → next packet (1,1,last) gives `m_data = 1`, `m_count = 1`.
- `COUNT_WIDTH = 2`, five beats of (1,1) → `m_count = 3` (saturated), `m_data = 5`.
